// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a one-entry skid buffer, a registered in_ready and a synchronous flush.
// Defining PIPE_STAGE_STATS_EN adds the saturating stall_cnt and flush_cnt counters.
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b11
   } state_t;

   state_t              state_reg, state_next;
   logic [DATA_W-1:0]   main_data_reg, main_data_next;
   logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
   logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
   logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;
   logic                accept;
   logic                emit;

   // Both handshake outputs come straight from the state register.
   assign in_ready  = (state_reg != SKID);
   assign out_valid = (state_reg != EMPTY);
   assign out_data  = main_data_reg;
   assign out_ctrl  = main_ctrl_reg;

   assign accept = in_valid && in_ready;
   assign emit   = out_valid && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= EMPTY;
         main_data_reg <= '0;
         main_ctrl_reg <= '0;
         skid_data_reg <= '0;
         skid_ctrl_reg <= '0;
      end else begin
         state_reg     <= state_next;
         main_data_reg <= main_data_next;
         main_ctrl_reg <= main_ctrl_next;
         skid_data_reg <= skid_data_next;
         skid_ctrl_reg <= skid_ctrl_next;
      end
   end

   // Every path into EMPTY clears main_ctrl so the control field of a bubble is a registered zero.
   always_comb begin
      state_next     = state_reg;
      main_data_next = main_data_reg;
      main_ctrl_next = main_ctrl_reg;
      skid_data_next = skid_data_reg;
      skid_ctrl_next = skid_ctrl_reg;

      if (flush) begin
         state_next     = EMPTY;
         main_ctrl_next = '0;
         skid_ctrl_next = '0;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  state_next     = FULL;
                  main_data_next = in_data;
                  main_ctrl_next = in_ctrl;
               end
            end
            FULL: begin
               if (accept && emit) begin
                  main_data_next = in_data;
                  main_ctrl_next = in_ctrl;
               end else if (accept) begin
                  state_next     = SKID;
                  skid_data_next = in_data;
                  skid_ctrl_next = in_ctrl;
               end else if (emit) begin
                  state_next     = EMPTY;
                  main_ctrl_next = '0;
               end
            end
            SKID: begin
               if (emit) begin
                  state_next     = FULL;
                  main_data_next = skid_data_reg;
                  main_ctrl_next = skid_ctrl_reg;
                  skid_data_next = '0;
                  skid_ctrl_next = '0;
               end
            end
            default: begin
               state_next     = EMPTY;
               main_ctrl_next = '0;
               skid_ctrl_next = '0;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         // A flush of an already empty stage killed nothing, so it is not counted.
         if (flush && (state_reg != EMPTY) && (flush_cnt_reg != {CNT_W{1'b1}}))
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: stimulus queues expected entries, a negedge monitor pops them on each emit.
module tb_pipe_stage_skid;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [DATA_W+CTRL_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one entry and hold it until accepted; optionally register it as expected output.
   task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input bit expect_out);
      bit hs;
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = c;
      if (expect_out) exp_q.push_back({d, c});
      n = 0;
      do begin
         hs = in_ready;
         tick();
         n++;
      end while (!hs && n < 50);
      if (!hs) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: data %0h not accepted within 50 cycles", d);
      end
      in_valid = 1'b0;
   endtask

   // Monitor: outputs are stable at the falling edge, and out_ready only changes just after a rising edge.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (out_valid === 1'b0) chk("bubble_ctrl_zero", 64'(out_ctrl), 64'h0);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mon_unexpected: got data %0h ctrl %0h expected no output", out_data, out_ctrl);
            end else begin
               logic [DATA_W+CTRL_W-1:0] e;
               e = exp_q.pop_front();
               chk("mon_entry", 64'({out_data, out_ctrl}), 64'(e));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_in_ready",  64'(in_ready),  64'h1);
      chk("rst_out_data",  64'(out_data),  64'h0);
      chk("rst_out_ctrl",  64'(out_ctrl),  64'h0);
`ifdef PIPE_STAGE_STATS_EN
      chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
      chk("rst_flush_cnt", 64'(flush_cnt), 64'h0);
`endif
      reset = 1'b1;
      tick();

      // Streaming with out_ready=1: one cycle latency, full throughput.
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h11; in_ctrl = 16'h0001; exp_q.push_back({32'h11, 16'h0001});
      tick();
      chk("s1_data_11", 64'(out_data), 64'h11);
      chk("s1_ready",   64'(in_ready), 64'h1);
      in_data = 32'h22; in_ctrl = 16'h0002; exp_q.push_back({32'h22, 16'h0002});
      tick();
      chk("s1_data_22", 64'(out_data), 64'h22);
      chk("s1_ready",   64'(in_ready), 64'h1);
      in_data = 32'h33; in_ctrl = 16'h0003; exp_q.push_back({32'h33, 16'h0003});
      tick();
      chk("s1_data_33", 64'(out_data), 64'h33);
      chk("s1_ready",   64'(in_ready), 64'h1);
      in_valid = 1'b0;
      tick();
      chk("s1_drained", 64'(out_valid), 64'h0);

      // Stall fills the skid entry; A2 waits upstream until space frees.
      send(32'hA0, 16'h00A0, 1'b1);
      out_ready = 1'b0;
      send(32'hA1, 16'h00A1, 1'b1);
      chk("s2_ready_low", 64'(in_ready), 64'h0);
      in_valid = 1'b1; in_data = 32'hA2; in_ctrl = 16'h00A2;
      tick();
      tick();
      chk("s2_hold_ready", 64'(in_ready), 64'h0);
      chk("s2_hold_data",  64'(out_data), 64'hA0);
      out_ready = 1'b1;
      send(32'hA2, 16'h00A2, 1'b1);
      repeat (3) tick();
      chk("s2_q_empty", 64'(exp_q.size()), 64'h0);

      // Flush from SKID with all-ones control; the entry offered in the flush cycle is lost.
      out_ready = 1'b0;
      send(32'hB0, 16'hFFFF, 1'b0);
      send(32'hB1, 16'hFFFF, 1'b0);
      chk("s3_skid", 64'(in_ready), 64'h0);
      in_valid = 1'b1; in_data = 32'hB2; in_ctrl = 16'hFFFF;
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("s3_out_valid", 64'(out_valid), 64'h0);
      chk("s3_out_ctrl",  64'(out_ctrl),  64'h0);
      chk("s3_in_ready",  64'(in_ready),  64'h1);
      out_ready = 1'b1;
      repeat (3) tick();

      // Flush and accept in the same cycle from EMPTY: 0x55 is discarded, 0x66 passes.
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'h0055;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("s4_no_55", 64'(out_valid), 64'h0);
      send(32'h66, 16'h0066, 1'b1);
      chk("s4_data_66", 64'(out_data), 64'h66);
      repeat (2) tick();

      // Emit during a flush still completes; the payload register keeps its value.
      send(32'h77, 16'h0077, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("s5_valid", 64'(out_valid), 64'h0);
      chk("s5_data_kept", 64'(out_data), 64'h77);
      chk("s5_ctrl", 64'(out_ctrl), 64'h0);
      tick();

      // Asynchronous reset with both entries valid, checked before the next clock edge.
      out_ready = 1'b0;
      send(32'hC0, 16'h00C0, 1'b0);
      send(32'hC1, 16'h00C1, 1'b0);
      chk("s6_skid", 64'(in_ready), 64'h0);
      #2 reset = 1'b0;
      #1;
      chk("s6_async_valid", 64'(out_valid), 64'h0);
      chk("s6_async_ctrl",  64'(out_ctrl),  64'h0);
      chk("s6_async_ready", 64'(in_ready),  64'h1);
      chk("s6_async_data",  64'(out_data),  64'h0);
      tick();
      reset = 1'b1;
      tick();

`ifdef PIPE_STAGE_STATS_EN
      // Statistics: stall counter saturates, flush of an empty stage is not counted.
      out_ready = 1'b0;
      send(32'hD0, 16'h00D0, 1'b0);
      repeat (20) tick();
      chk("st_stall_sat", 64'(stall_cnt), 64'hF);
      flush = 1'b1; tick(); flush = 1'b0;
      flush = 1'b1; tick(); flush = 1'b0;
      send(32'hE0, 16'h00E0, 1'b0);
      flush = 1'b1; tick(); flush = 1'b0;
      tick();
      chk("st_flush_cnt", 64'(flush_cnt), 64'h2);
      chk("st_stall_held", 64'(stall_cnt), 64'hF);
`endif

      tick();
      chk("final_q_empty", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
